apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB requester that drives the GCD wrapper's APB register-file slave from an on-chip agent (test sequencer, boot ROM engine or host bridge). Accepts one command at a time on a valid/ready request channel and runs a complete APB SETUP/ACCESS transfer. Returns read data and an error status on a valid/ready response channel. Includes a programmable PREADY timeout so a hung slave cannot lock the requester.

## Interface
Parameters:
- ADDR_WIDTH, 32, PADDR and REQ_ADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA/REQ_WDATA/RSP_RDATA width
- TIMEOUT_CYCLES, 255, ACCESS-phase wait-state limit; 0 disables the timeout

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - CLK  in  1  clock
  - RESETn  in  1  reset
- Request channel:
  - REQ_VALID  in  1  command valid
  - REQ_READY  out  1  command accepted when high with REQ_VALID
  - REQ_ADDR  in  ADDR_WIDTH  byte address
  - REQ_WRITE  in  1  1 = write, 0 = read
  - REQ_WDATA  in  DATA_WIDTH  write data
- Response channel:
  - RSP_VALID  out  1  response valid
  - RSP_READY  in  1  response consumed
  - RSP_RDATA  out  DATA_WIDTH  read data; 0 for writes and timeouts
  - RSP_ERR  out  1  PSLVERR seen or timeout
  - RSP_TIMEOUT  out  1  transfer aborted by timeout
- APB requester side:
  - PADDR  out  ADDR_WIDTH
  - PSEL  out  1
  - PENABLE  out  1
  - PWRITE  out  1
  - PWDATA  out  DATA_WIDTH
  - PRDATA  in  DATA_WIDTH
  - PREADY  in  1
  - PSLVERR  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. The reset state is IDLE.
- IDLE:
  - REQ_READY = 1.
  - On REQ_VALID, register REQ_ADDR, REQ_WRITE and REQ_WDATA into PADDR, PWRITE and PWDATA, then go to SETUP.
- SETUP: PSEL = 1, PENABLE = 0. Always go to ACCESS next cycle.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - On PREADY = 1:
    - Capture PRDATA into RSP_RDATA for reads only; writes give 0.
    - Capture PSLVERR into RSP_ERR.
    - Set RSP_TIMEOUT = 0 and go to RESP.
  - On PREADY = 0, increment the wait counter.
  - When the counter equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES ≠ 0), set RSP_ERR = 1, RSP_TIMEOUT = 1, RSP_RDATA = 0 and go to RESP. PSEL/PENABLE drop with the transition; this is a deliberate protocol abort.
- RESP:
  - RSP_VALID = 1; response fields are stable while RSP_VALID is high.
  - On RSP_READY, go to IDLE.
- Counter rules:
  - Width is clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
  - Cleared on entry to ACCESS; saturates, never wraps.
- PADDR/PWRITE/PWDATA hold their last value outside transfers. They change only on request acceptance.
- REQ_READY is low in SETUP, ACCESS and RESP. No second command is accepted until the response has been consumed.
- Reset mid-transfer: all outputs go immediately to their reset values and the FSM returns to IDLE. The in-flight transfer is lost and no response is produced.

## Timing
- Output reset values:
  - REQ_READY = 1 once RESETn is high; 0 while RESETn is low.
  - RSP_VALID = 0, RSP_RDATA = 0, RSP_ERR = 0, RSP_TIMEOUT = 0.
  - PADDR = 0, PSEL = 0, PENABLE = 0, PWRITE = 0, PWDATA = 0.
- All outputs are registered or decoded directly from state; there is no combinational path from PREADY/PRDATA to the APB outputs.
- Zero-wait transfer, with acceptance at cycle 0:
  - cycle 1 is SETUP;
  - cycle 2 is ACCESS with PREADY = 1;
  - cycle 3 has RSP_VALID = 1.
- With RSP_READY held high, RSP_VALID lasts 1 cycle and REQ_READY returns in cycle 4. Peak throughput is one transfer per 4 cycles.
- Each wait state adds 1 cycle.
- Timeout boundary: PREADY = 1 in the same cycle the counter reaches the limit is a normal completion; completion wins over timeout.
- RSP_READY asserted before RSP_VALID has no effect. RSP_VALID never drops without RSP_READY.

## Structure
- Shared package gcd_apb_pkg:
  - the apb_master_state_t enum (IDLE/SETUP/ACCESS/RESP);
  - APB_ADDR_WIDTH / APB_DATA_WIDTH defaults;
  - the register-file address map constants used by benches and sequencers.
- Single module with no sub-module. The timeout counter is small enough to stay inline.

## Test plan
- Write 0x0000_0004 ← 0x0000_00A5 with zero wait states:
  - PSEL rises in cycle 1 and PENABLE in cycle 2;
  - PWRITE = 1 and PWDATA = 0xA5 are stable across both;
  - RSP_VALID in cycle 3 with RSP_ERR = 0 and RSP_RDATA = 0.
- Read 0x0000_0008 with 3 wait states and PRDATA = 0xDEAD_BEEF:
  - ACCESS lasts 4 cycles;
  - RSP_RDATA = 0xDEADBEEF, RSP_ERR = 0.
- Read with PSLVERR = 1 on the completing cycle → RSP_ERR = 1, RSP_TIMEOUT = 0.
- TIMEOUT_CYCLES = 4 and PREADY held low → abort after 4 ACCESS cycles with RSP_ERR = 1, RSP_TIMEOUT = 1 and PSEL = 0 in RESP. A second run with PREADY = 1 on the 4th cycle completes normally.
- Response backpressure: RSP_READY held low for 10 cycles with REQ_VALID high →
  - RSP fields are stable;
  - REQ_READY stays 0 and no new PSEL appears;
  - the next command is accepted the cycle after the RSP handshake.
- RESETn pulsed low during ACCESS → PSEL/PENABLE/RSP_VALID are 0 asynchronously and no response appears after release.

Source files
------------

// File: rtl/gcd_apb_pkg.sv
// Shared types and constants for the GCD wrapper APB path.
// The register map is used by benches and sequencers driving the slave.
package gcd_apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    localparam logic [31:0] GCD_REG_CTRL   = 32'h0000_0000;
    localparam logic [31:0] GCD_REG_OPA    = 32'h0000_0004;
    localparam logic [31:0] GCD_REG_OPB    = 32'h0000_0008;
    localparam logic [31:0] GCD_REG_RESULT = 32'h0000_000C;
    localparam logic [31:0] GCD_REG_STATUS = 32'h0000_0010;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_master_state_t;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB requester with valid/ready command and
// response channels and a PREADY wait-state timeout.
module apb_master
    import gcd_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic                  REQ_WRITE,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    apb_master_state_t state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              to_hit;

    // The wait that would bring the counter to the limit aborts instead.
    assign to_hit = TO_EN && (wait_cnt == CNT_LAST) && !PREADY;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (REQ_VALID) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (PREADY || to_hit) state_nxt = RESP;
            RESP:    if (RSP_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign REQ_READY = (state == IDLE) && RESETn;
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign RSP_VALID = (state == RESP);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (state == IDLE && REQ_VALID) begin
            PADDR  <= REQ_ADDR;
            PWRITE <= REQ_WRITE;
            PWDATA <= REQ_WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
        end else if (state == ACCESS) begin
            if (PREADY) begin
                RSP_RDATA   <= PWRITE ? '0 : PRDATA;
                RSP_ERR     <= PSLVERR;
                RSP_TIMEOUT <= 1'b0;
            end else if (to_hit) begin
                RSP_RDATA   <= '0;
                RSP_ERR     <= 1'b1;
                RSP_TIMEOUT <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: vector table, hand sequences
// and randomized transfers against a transfer-level reference model.
module tb_apb_master;
    import gcd_apb_pkg::*;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        REQ_VALID, REQ_READY, REQ_WRITE;
    logic [31:0] REQ_ADDR, REQ_WDATA;
    logic        RSP_VALID, RSP_READY, RSP_ERR, RSP_TIMEOUT;
    logic [31:0] RSP_RDATA;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    apb_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RESETn(RESETn),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_ADDR(REQ_ADDR), .REQ_WRITE(REQ_WRITE),
        .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .RSP_TIMEOUT(RSP_TIMEOUT),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    int          obs_acc, obs_rsp, obs_first_sel, obs_first_en;
    logic [31:0] obs_rdata;
    logic        obs_err, obs_to, obs_psel_resp, obs_unstable;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_acc;
        int          exp_rsp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Acts as the APB slave from the SETUP cycle until RSP_VALID.
    task automatic serve(input int waits, input logic [31:0] prd,
                         input logic se, input logic [31:0] a,
                         input logic w, input logic [31:0] wd);
        int  cyc = 1;
        int  acc = 0;
        bit  found = 0;
        obs_acc = 0; obs_rsp = -1; obs_first_sel = -1;
        obs_first_en = -1; obs_unstable = 0;
        obs_rdata = 'x; obs_err = 1'bx; obs_to = 1'bx;
        obs_psel_resp = 1'bx;
        for (int k = 0; k < 40 && !found; k++) begin
            if (RSP_VALID) begin
                found = 1;
                obs_rsp = cyc; obs_rdata = RSP_RDATA;
                obs_err = RSP_ERR; obs_to = RSP_TIMEOUT;
                obs_psel_resp = PSEL;
                obs_acc = acc;
                PREADY = 1'b0;
            end else begin
                if (PSEL) begin
                    if (obs_first_sel < 0) obs_first_sel = cyc;
                    if (PADDR !== a || PWRITE !== w || PWDATA !== wd)
                        obs_unstable = 1;
                end
                if (PSEL && PENABLE) begin
                    if (obs_first_en < 0) obs_first_en = cyc;
                    acc++;
                    PREADY  = (acc == waits + 1);
                    PRDATA  = PREADY ? prd : $urandom;
                    PSLVERR = PREADY ? se : 1'($urandom);
                end else begin
                    PREADY = 1'b0;
                end
                @(negedge CLK);
                cyc++;
            end
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input int waits,
                        input logic [31:0] prd, input logic se);
        chk("req_ready_idle", REQ_READY, 1);
        REQ_VALID = 1; REQ_ADDR = a; REQ_WRITE = w; REQ_WDATA = wd;
        @(negedge CLK);
        REQ_VALID = 0;
        REQ_ADDR = $urandom; REQ_WDATA = $urandom;
        serve(waits, prd, se, a, w, wd);
    endtask

    task automatic consume();
        RSP_READY = 1;
        @(negedge CLK);
        RSP_READY = 0;
        chk("req_ready_after_rsp", REQ_READY, 1);
        chk("rsp_valid_after_rsp", RSP_VALID, 0);
    endtask

    task automatic check_xfer(string t, logic [31:0] er, logic ee,
                              logic et, int ea, int ersp);
        chk({t, "_rdata"}, obs_rdata, er);
        chk({t, "_err"}, 32'(obs_err), 32'(ee));
        chk({t, "_timeout"}, 32'(obs_to), 32'(et));
        chk({t, "_access_cycles"}, obs_acc, ea);
        chk({t, "_rsp_cycle"}, obs_rsp, ersp);
        chk({t, "_psel_cycle"}, obs_first_sel, 1);
        chk({t, "_penable_cycle"}, obs_first_en, 2);
        chk({t, "_psel_in_resp"}, 32'(obs_psel_resp), 0);
        chk({t, "_apb_stable"}, 32'(obs_unstable), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        RESETn = 1; REQ_VALID = 0; REQ_ADDR = 0; REQ_WRITE = 0;
        REQ_WDATA = 0; RSP_READY = 0; PRDATA = 0; PREADY = 0;
        PSLVERR = 0;
        #2 RESETn = 0;
        #2;
        chk("rst_req_ready", REQ_READY, 0);
        chk("rst_psel", {PSEL, PENABLE, RSP_VALID}, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp", {RSP_RDATA[3:0], RSP_ERR, RSP_TIMEOUT, PWRITE}, 0);
        repeat (3) @(negedge CLK);
        RESETn = 1;
        #1 chk("rst_release_ready", REQ_READY, 1);
        @(negedge CLK);

        vecs[0] = '{GCD_REG_OPA, 1'b1, 32'hA5, 0, 32'h5555_AAAA, 1'b0,
                    32'h0, 1'b0, 1'b0, 1, 3};
        vecs[1] = '{GCD_REG_OPB, 1'b0, 32'h1, 3, 32'hDEAD_BEEF, 1'b0,
                    32'hDEAD_BEEF, 1'b0, 1'b0, 4, 6};
        vecs[2] = '{GCD_REG_RESULT, 1'b0, 32'h2, 1, 32'h1234_5678, 1'b1,
                    32'h1234_5678, 1'b1, 1'b0, 2, 4};
        vecs[3] = '{GCD_REG_STATUS, 1'b0, 32'h3, 9, 32'hCAFE_F00D, 1'b0,
                    32'h0, 1'b1, 1'b1, 4, 6};
        vecs[4] = '{GCD_REG_CTRL, 1'b0, 32'h4, 3, 32'h0BAD_CAFE, 1'b0,
                    32'h0BAD_CAFE, 1'b0, 1'b0, 4, 6};
        vecs[5] = '{GCD_REG_OPB, 1'b1, 32'h77, 2, 32'hFFFF_FFFF, 1'b1,
                    32'h0, 1'b1, 1'b0, 3, 5};

        for (int i = 0; i < 6; i++) begin
            xfer(vecs[i].addr, vecs[i].write, vecs[i].wdata,
                 vecs[i].waits, vecs[i].prdata, vecs[i].slverr);
            check_xfer($sformatf("v%0d", i), vecs[i].exp_rdata,
                       vecs[i].exp_err, vecs[i].exp_to,
                       vecs[i].exp_acc, vecs[i].exp_rsp);
            consume();
        end

        // Response backpressure with a new command waiting.
        xfer(GCD_REG_OPA, 1'b0, 32'h9, 0, 32'h1357_9BDF, 1'b0);
        chk("bp_first_rdata", obs_rdata, 32'h1357_9BDF);
        REQ_VALID = 1; REQ_ADDR = GCD_REG_RESULT;
        REQ_WRITE = 0; REQ_WDATA = 32'h55;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (RSP_VALID !== 1 || RSP_RDATA !== 32'h1357_9BDF ||
                RSP_ERR !== 0 || RSP_TIMEOUT !== 0 ||
                REQ_READY !== 0 || PSEL !== 0)
                bad = 1;
        end
        chk("bp_hold", 32'(bad), 0);
        RSP_READY = 1;
        @(negedge CLK);
        RSP_READY = 0;
        chk("bp_ready_after_hs", REQ_READY, 1);
        @(negedge CLK);
        REQ_VALID = 0;
        chk("bp_next_setup", {PSEL, PENABLE}, 2'b10);
        chk("bp_next_paddr", PADDR, GCD_REG_RESULT);
        serve(0, 32'h2468_ACE0, 1'b0, GCD_REG_RESULT, 1'b0, 32'h55);
        chk("bp_next_rdata", obs_rdata, 32'h2468_ACE0);
        chk("bp_next_rsp_cycle", obs_rsp, 3);
        consume();

        // Reset during ACCESS.
        REQ_VALID = 1; REQ_ADDR = GCD_REG_OPB; REQ_WRITE = 1;
        REQ_WDATA = 32'hABCD;
        @(negedge CLK);
        REQ_VALID = 0;
        @(negedge CLK);
        chk("mid_rst_in_access", {PSEL, PENABLE}, 2'b11);
        #2 RESETn = 0;
        #1;
        chk("mid_rst_apb", {PSEL, PENABLE, RSP_VALID}, 0);
        chk("mid_rst_req_ready", REQ_READY, 0);
        chk("mid_rst_paddr", PADDR, 0);
        @(negedge CLK);
        RESETn = 1;
        PREADY = 1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (RSP_VALID !== 0 || PSEL !== 0 || REQ_READY !== 1)
                bad = 1;
        end
        PREADY = 0;
        chk("mid_rst_no_rsp", 32'(bad), 0);

        // Randomized transfers against a transfer-level model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, wd, prd, er;
            logic        w, se, to, ee;
            int          waits, ea;
            a = {$urandom_range(0, 4), 2'b00};
            w = 1'($urandom); wd = $urandom; prd = $urandom;
            se = ($urandom_range(0, 3) == 0);
            waits = $urandom_range(0, 6);
            to = (waits >= TO);
            ee = to ? 1'b1 : se;
            er = (to || w) ? 32'h0 : prd;
            ea = to ? TO : waits + 1;
            xfer(a, w, wd, waits, prd, se);
            check_xfer($sformatf("r%0d", i), er, ee, to, ea, ea + 2);
            consume();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
